// File: rtl/suprloco_rom_port_arbiter.sv
// ROM port arbiter: buffers the ioctl download stream in a small write FIFO,
// filters out-of-range bytes, and shares one memory port between download
// writes and a runtime byte reader. Also raises the download-done level that
// lets the core leave reset once every buffered byte has reached memory.
module suprloco_rom_port_arbiter #(
  parameter int              AW       = 17,
  parameter int              FIFO_DEP = 4,
  parameter logic [AW-1:0]   ROM_END  = 17'h1A620
) (
  input  logic          i_EMU_MCLK,
  input  logic          i_EMU_INITRST,
  input  logic          i_DL_ACTIVE,
  input  logic          i_DL_WR,
  input  logic [26:0]   i_DL_ADDR,
  input  logic [7:0]    i_DL_DATA,
  output logic          o_DL_WAIT,
  output logic          o_DL_DONE,
  output logic          o_ERR_OOR,
  output logic          o_ERR_OVF,
  input  logic          i_RD_REQ,
  input  logic [AW-1:0] i_RD_ADDR,
  output logic          o_RD_ACK,
  output logic [7:0]    o_RD_DATA,
  output logic          o_MEM_REQ,
  output logic          o_MEM_WE,
  output logic [AW-1:0] o_MEM_ADDR,
  output logic [7:0]    o_MEM_DIN,
  input  logic          i_MEM_ACK,
  input  logic [7:0]    i_MEM_DOUT
);

  localparam int PW = (FIFO_DEP > 1) ? $clog2(FIFO_DEP) : 1;
  localparam int CW = $clog2(FIFO_DEP + 1);
  localparam int EW = AW + 8;
  localparam logic [CW-1:0] DEP_C  = CW'(FIFO_DEP);
  localparam logic [CW-1:0] WAIT_C = CW'(FIFO_DEP - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t        state;

  // Write FIFO: each entry is {address, data}
  logic [EW-1:0] fifo_mem [FIFO_DEP];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [EW-1:0] fifo_head;

  logic          dl_push_req;
  logic          addr_oor;
  logic          fifo_full;
  logic          push_ok;
  logic          push_ovf;
  logic          pop;

  logic          dl_active_q;
  logic          fall_seen;

  // Classify the incoming download byte and compute the next FIFO occupancy
  always_comb begin
    dl_push_req = i_DL_WR & i_DL_ACTIVE;
    addr_oor    = (i_DL_ADDR[26:AW] != '0) || (i_DL_ADDR[AW-1:0] >= ROM_END);
    // Fullness is judged on the current count, so a pop in the same cycle
    // does not rescue a byte that arrives while the FIFO is full.
    fifo_full   = (count == DEP_C);
    push_ok     = dl_push_req & ~addr_oor & ~fifo_full;
    push_ovf    = dl_push_req & ~addr_oor & fifo_full;
    pop         = (state == S_WRITE) & i_MEM_ACK;
    count_nxt   = count + CW'(push_ok) - CW'(pop);
    fifo_head   = fifo_mem[rd_ptr];
  end

  // FIFO storage; contents need no reset because occupancy is tracked separately
  always_ff @(posedge i_EMU_MCLK) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= {i_DL_ADDR[AW-1:0], i_DL_DATA};
    end
  end

  // FIFO pointers, occupancy, backpressure and sticky drop flags
  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_INITRST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      o_DL_WAIT <= 1'b0;
      o_ERR_OOR <= 1'b0;
      o_ERR_OVF <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_nxt;
      // Assert one entry early: the ioctl side may still deliver a byte
      // in the cycle after it sees the wait.
      o_DL_WAIT <= (count_nxt >= WAIT_C);
      if (dl_push_req & addr_oor) begin
        o_ERR_OOR <= 1'b1;
      end
      if (push_ovf) begin
        o_ERR_OVF <= 1'b1;
      end
    end
  end

  // Memory port FSM: download writes take priority over runtime reads
  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_INITRST) begin
      state      <= S_IDLE;
      o_MEM_REQ  <= 1'b0;
      o_MEM_WE   <= 1'b0;
      o_MEM_ADDR <= '0;
      o_MEM_DIN  <= '0;
      o_RD_ACK   <= 1'b0;
      o_RD_DATA  <= 8'h00;
    end else begin
      o_RD_ACK <= 1'b0;
      case (state)
        S_IDLE: begin
          if (count != '0) begin
            state      <= S_WRITE;
            o_MEM_REQ  <= 1'b1;
            o_MEM_WE   <= 1'b1;
            o_MEM_ADDR <= fifo_head[EW-1:8];
            o_MEM_DIN  <= fifo_head[7:0];
          end else if (i_RD_REQ) begin
            state      <= S_READ;
            o_MEM_REQ  <= 1'b1;
            o_MEM_WE   <= 1'b0;
            o_MEM_ADDR <= i_RD_ADDR;
          end
        end
        S_WRITE: begin
          // Head entry stays on the bus; the pop happens on this same ACK
          if (i_MEM_ACK) begin
            o_MEM_REQ <= 1'b0;
            state     <= S_GAP;
          end
        end
        S_READ: begin
          // Finishes even if the requester has since withdrawn
          if (i_MEM_ACK) begin
            o_MEM_REQ <= 1'b0;
            o_RD_DATA <= i_MEM_DOUT;
            o_RD_ACK  <= 1'b1;
            state     <= S_GAP;
          end
        end
        S_GAP: begin
          // Dead cycle lets the requester drop i_RD_REQ after o_RD_ACK
          state <= S_IDLE;
        end
        default: begin
          state     <= S_IDLE;
          o_MEM_REQ <= 1'b0;
        end
      endcase
    end
  end

  // Download-done level: needs a completed download and a drained write path
  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_INITRST) begin
      dl_active_q <= 1'b0;
      fall_seen   <= 1'b0;
      o_DL_DONE   <= 1'b0;
    end else begin
      dl_active_q <= i_DL_ACTIVE;
      if (i_DL_ACTIVE & ~dl_active_q) begin
        fall_seen <= 1'b0;
        o_DL_DONE <= 1'b0;
      end else if (~i_DL_ACTIVE) begin
        if (dl_active_q) begin
          fall_seen <= 1'b1;
        end
        if ((fall_seen | dl_active_q) && (count == '0) && (state == S_IDLE)) begin
          o_DL_DONE <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_suprloco_rom_port_arbiter.sv
// Directed bench for the ROM port arbiter: download ordering and latency,
// overflow and range filtering, read arbitration, reset abort and done flag.
module tb_suprloco_rom_port_arbiter;

  localparam int AW = 17;

  logic          i_EMU_MCLK = 1'b0;
  logic          i_EMU_INITRST;
  logic          i_DL_ACTIVE;
  logic          i_DL_WR;
  logic [26:0]   i_DL_ADDR;
  logic [7:0]    i_DL_DATA;
  logic          o_DL_WAIT;
  logic          o_DL_DONE;
  logic          o_ERR_OOR;
  logic          o_ERR_OVF;
  logic          i_RD_REQ;
  logic [AW-1:0] i_RD_ADDR;
  logic          o_RD_ACK;
  logic [7:0]    o_RD_DATA;
  logic          o_MEM_REQ;
  logic          o_MEM_WE;
  logic [AW-1:0] o_MEM_ADDR;
  logic [7:0]    o_MEM_DIN;
  logic          i_MEM_ACK = 1'b0;
  logic [7:0]    i_MEM_DOUT = 8'h00;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  suprloco_rom_port_arbiter #(
    .AW       (17),
    .FIFO_DEP (4),
    .ROM_END  (17'h1A620)
  ) dut (
    .i_EMU_MCLK    (i_EMU_MCLK),
    .i_EMU_INITRST (i_EMU_INITRST),
    .i_DL_ACTIVE   (i_DL_ACTIVE),
    .i_DL_WR       (i_DL_WR),
    .i_DL_ADDR     (i_DL_ADDR),
    .i_DL_DATA     (i_DL_DATA),
    .o_DL_WAIT     (o_DL_WAIT),
    .o_DL_DONE     (o_DL_DONE),
    .o_ERR_OOR     (o_ERR_OOR),
    .o_ERR_OVF     (o_ERR_OVF),
    .i_RD_REQ      (i_RD_REQ),
    .i_RD_ADDR     (i_RD_ADDR),
    .o_RD_ACK      (o_RD_ACK),
    .o_RD_DATA     (o_RD_DATA),
    .o_MEM_REQ     (o_MEM_REQ),
    .o_MEM_WE      (o_MEM_WE),
    .o_MEM_ADDR    (o_MEM_ADDR),
    .o_MEM_DIN     (o_MEM_DIN),
    .i_MEM_ACK     (i_MEM_ACK),
    .i_MEM_DOUT    (i_MEM_DOUT)
  );

  always #5 i_EMU_MCLK = ~i_EMU_MCLK;

  always @(posedge i_EMU_MCLK) cyc <= cyc + 1;

  // Memory model: when enabled, acknowledges in the first cycle it sees a
  // request, returns 0x5A on reads, and logs every completed transaction.
  logic          mem_auto = 1'b0;
  int            log_n    = 0;
  logic [AW-1:0] log_addr [64];
  logic [7:0]    log_din  [64];
  logic          log_we   [64];
  int            log_cyc  [64];

  always @(posedge i_EMU_MCLK) begin
    #1;
    if (mem_auto && o_MEM_REQ && !i_MEM_ACK) begin
      i_MEM_ACK  = 1'b1;
      i_MEM_DOUT = o_MEM_WE ? 8'h00 : 8'h5A;
      if (log_n < 64) begin
        log_addr[log_n] = o_MEM_ADDR;
        log_din[log_n]  = o_MEM_DIN;
        log_we[log_n]   = o_MEM_WE;
        log_cyc[log_n]  = cyc;
      end
      log_n++;
    end else begin
      i_MEM_ACK  = 1'b0;
      i_MEM_DOUT = 8'h00;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_EMU_MCLK);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    i_EMU_INITRST = 1'b1;
    i_DL_ACTIVE   = 1'b0;
    i_DL_WR       = 1'b0;
    i_DL_ADDR     = '0;
    i_DL_DATA     = '0;
    i_RD_REQ      = 1'b0;
    i_RD_ADDR     = '0;
    tick();
    tick();
    i_EMU_INITRST = 1'b0;
  endtask

  task automatic push(input logic [26:0] a, input logic [7:0] d);
    i_DL_WR   = 1'b1;
    i_DL_ADDR = a;
    i_DL_DATA = d;
    tick();
    i_DL_WR   = 1'b0;
  endtask

  int lb;
  int c0;
  int acks;
  int dc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    do_reset();
    chk("rst_req",    o_MEM_REQ, 0);
    chk("rst_wait",   o_DL_WAIT, 0);
    chk("rst_done",   o_DL_DONE, 0);
    chk("rst_oor",    o_ERR_OOR, 0);
    chk("rst_ovf",    o_ERR_OVF, 0);
    chk("rst_rdack",  o_RD_ACK, 0);
    chk("rst_rddata", o_RD_DATA, 8'h00);
    chk("rst_addr",   o_MEM_ADDR, 0);
    ticks(3);
    chk("rst_no_done", o_DL_DONE, 0);

    // 1: two bytes, latency N+2, 3-cycle spacing, done after ACTIVE falls
    do_reset();
    mem_auto = 1'b1;
    lb = log_n;
    i_DL_ACTIVE = 1'b1;
    tick();
    c0 = cyc;
    i_DL_WR = 1'b1; i_DL_ADDR = 27'h0; i_DL_DATA = 8'hAA;
    tick();
    chk("t1_req_n1", o_MEM_REQ, 0);
    i_DL_ADDR = 27'h1; i_DL_DATA = 8'hBB;
    tick();
    i_DL_WR = 1'b0; i_DL_ACTIVE = 1'b0;
    chk("t1_req_n2", o_MEM_REQ, 1);
    chk("t1_we", o_MEM_WE, 1);
    while (cyc < c0 + 7) tick();
    chk("t1_done_early", o_DL_DONE, 0);
    tick();
    chk("t1_done", o_DL_DONE, 1);
    chk("t1_nwr", log_n - lb, 2);
    chk("t1_a0", log_addr[lb], 17'h00000);
    chk("t1_d0", log_din[lb], 8'hAA);
    chk("t1_w0", log_we[lb], 1);
    chk("t1_c0", log_cyc[lb] - c0, 2);
    chk("t1_a1", log_addr[lb+1], 17'h00001);
    chk("t1_d1", log_din[lb+1], 8'hBB);
    chk("t1_sp", log_cyc[lb+1] - log_cyc[lb], 3);

    // 2: overflow with memory stalled
    do_reset();
    mem_auto = 1'b0;
    lb = log_n;
    i_DL_ACTIVE = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      i_DL_WR = 1'b1; i_DL_ADDR = 27'(16 + i); i_DL_DATA = 8'(32 + i);
      tick();
      chk($sformatf("t2_wait%0d", i), o_DL_WAIT, (i >= 2));
      chk($sformatf("t2_ovf%0d", i), o_ERR_OVF, (i == 4));
    end
    i_DL_WR = 1'b0; i_DL_ACTIVE = 1'b0;
    chk("t2_req", o_MEM_REQ, 1);
    chk("t2_addr", o_MEM_ADDR, 17'h10);
    mem_auto = 1'b1;
    ticks(25);
    chk("t2_nwr", log_n - lb, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_a%0d", i), log_addr[lb+i], 17'(16 + i));
      chk($sformatf("t2_d%0d", i), log_din[lb+i], 8'(32 + i));
    end
    chk("t2_wait_end", o_DL_WAIT, 0);
    chk("t2_ovf_stk", o_ERR_OVF, 1);
    chk("t2_oor", o_ERR_OOR, 0);
    chk("t2_done", o_DL_DONE, 1);

    // 3: range filter
    do_reset();
    mem_auto = 1'b1;
    lb = log_n;
    push(27'h1A620, 8'h11);
    tick();
    chk("t3_inactive", o_ERR_OOR, 0);
    i_DL_ACTIVE = 1'b1;
    push(27'h20000, 8'h22);
    chk("t3_oor_hi", o_ERR_OOR, 1);
    ticks(4);
    chk("t3_hi_nwr", log_n - lb, 0);
    do_reset();
    lb = log_n;
    i_DL_ACTIVE = 1'b1;
    push(27'h1A620, 8'h11);
    chk("t3_oor_end", o_ERR_OOR, 1);
    ticks(4);
    chk("t3_end_nwr", log_n - lb, 0);
    push(27'h1A61F, 8'h33);
    ticks(4);
    chk("t3_nwr", log_n - lb, 1);
    chk("t3_a", log_addr[lb], 17'h1A61F);
    chk("t3_d", log_din[lb], 8'h33);
    chk("t3_ovf", o_ERR_OVF, 0);

    // 4: read waits behind buffered writes
    do_reset();
    mem_auto = 1'b1;
    lb = log_n;
    i_DL_ACTIVE = 1'b1;
    tick();
    push(27'h100, 8'h61);
    push(27'h101, 8'h62);
    i_RD_REQ = 1'b1; i_RD_ADDR = 17'h0C000;
    acks = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (o_RD_ACK) begin
        acks++;
        chk("t4_rdata", o_RD_DATA, 8'h5A);
        chk("t4_order", log_n - lb, 3);
        i_RD_REQ = 1'b0;
      end
    end
    chk("t4_acks", acks, 1);
    chk("t4_w0", log_we[lb], 1);
    chk("t4_a0", log_addr[lb], 17'h100);
    chk("t4_w1", log_we[lb+1], 1);
    chk("t4_a1", log_addr[lb+1], 17'h101);
    chk("t4_w2", log_we[lb+2], 0);
    chk("t4_a2", log_addr[lb+2], 17'h0C000);
    chk("t4_hold", o_RD_DATA, 8'h5A);

    // 5: reset in the middle of a write
    do_reset();
    mem_auto = 1'b0;
    lb = log_n;
    i_DL_ACTIVE = 1'b1;
    tick();
    push(27'h1FFFF, 8'h00);
    push(27'h300, 8'h44);
    push(27'h301, 8'h45);
    chk("t5_req", o_MEM_REQ, 1);
    chk("t5_oor", o_ERR_OOR, 1);
    i_EMU_INITRST = 1'b1;
    tick();
    i_EMU_INITRST = 1'b0;
    i_DL_ACTIVE = 1'b0;
    chk("t5_req_rst", o_MEM_REQ, 0);
    chk("t5_oor_rst", o_ERR_OOR, 0);
    chk("t5_wait_rst", o_DL_WAIT, 0);
    chk("t5_done_rst", o_DL_DONE, 0);
    mem_auto = 1'b1;
    ticks(6);
    chk("t5_empty", log_n - lb, 0);
    chk("t5_req_idle", o_MEM_REQ, 0);
    chk("t5_no_done", o_DL_DONE, 0);
    i_DL_ACTIVE = 1'b1;
    tick();
    push(27'h302, 8'h46);
    i_DL_ACTIVE = 1'b0;
    dc = -1;
    for (int i = 0; i < 20 && dc < 0; i++) begin
      tick();
      if (o_DL_DONE) dc = cyc;
    end
    chk("t5_done", (dc >= 0), 1);
    chk("t5_nwr", log_n - lb, 1);
    chk("t5_a", log_addr[lb], 17'h302);
    chk("t5_d", log_din[lb], 8'h46);

    // 6: done waits for the drain, and clears on a new download
    do_reset();
    mem_auto = 1'b0;
    lb = log_n;
    i_DL_ACTIVE = 1'b1;
    tick();
    push(27'h400, 8'h99);
    i_DL_ACTIVE = 1'b0;
    ticks(5);
    chk("t6_done_pend", o_DL_DONE, 0);
    chk("t6_req_pend", o_MEM_REQ, 1);
    mem_auto = 1'b1;
    dc = -1;
    for (int i = 0; i < 20 && dc < 0; i++) begin
      tick();
      if (o_DL_DONE) dc = cyc;
    end
    chk("t6_done_seen", (dc >= 0), 1);
    chk("t6_nwr", log_n - lb, 1);
    chk("t6_lat", dc - log_cyc[lb], 3);
    ticks(3);
    chk("t6_done_lvl", o_DL_DONE, 1);
    i_DL_ACTIVE = 1'b1;
    tick();
    chk("t6_done_clr", o_DL_DONE, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
